// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INSTR   = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating stall counter; expired flags when the count reaches LIMIT.
// LIMIT=0 disables the watchdog (expired never asserts).
module arb_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] count_r;

  // Stall counter: clear wins over increment, saturates once expired.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= '0;
    end else if (inc && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (LIMIT != 0) && (count_r == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and data
// load/store, one transaction at a time, with a waitrequest watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_READDATA   = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_ready,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_ready,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        busy,
  output logic        bus_error
);

  arb_state_e  state_r, state_next_s;
  grant_e      last_grant_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  be_r;
  logic        bus_error_r;

  logic        data_req_s, grant_data_s;
  logic        active_s, stall_s, done_s, abort_s, expired_s, finish_s;
  logic [31:0] rdata_s;

  assign data_req_s   = data_read | data_write;
  // Round-robin: a tie goes to data unless data was the last side served.
  assign grant_data_s = data_req_s &&
                        (DATA_PRIORITY || !instr_req || (last_grant_r == GRANT_INSTR));
  assign active_s     = (state_r != IDLE);
  assign stall_s      = active_s && bus_waitrequest;
  assign done_s       = active_s && !bus_waitrequest;
  assign abort_s      = stall_s && expired_s;

  // Next-state: arbitrate in IDLE, leave a granted state on completion or abort.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_data_s) begin
          state_next_s = data_write ? DATA_WR : DATA_RD;
        end else if (instr_req) begin
          state_next_s = INSTR;
        end else begin
          state_next_s = IDLE;
        end
      end
      INSTR, DATA_RD, DATA_WR: begin
        if (done_s || abort_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, grant history, captured request and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_INSTR;
      addr_r       <= 32'h0;
      wdata_r      <= 32'h0;
      be_r         <= 4'h0;
      bus_error_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (abort_s) begin
        bus_error_r <= 1'b1;
      end
      if (!active_s && grant_data_s) begin
        last_grant_r <= GRANT_DATA;
        addr_r       <= data_address;
        wdata_r      <= data_writedata;
        be_r         <= data_byteenable;
      end else if (!active_s && instr_req) begin
        last_grant_r <= GRANT_INSTR;
        addr_r       <= instr_address;
        wdata_r      <= 32'h0;
        be_r         <= BE_ALL;
      end
    end
  end

  arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .inc    (stall_s),
    .clr    (state_next_s == IDLE),
    .expired(expired_s)
  );

  // Bus is driven only from the captured request; IDLE drives all zeros.
  assign busy           = active_s;
  assign bus_read       = (state_r == INSTR) || (state_r == DATA_RD);
  assign bus_write      = (state_r == DATA_WR);
  assign bus_address    = active_s ? addr_r : 32'h0;
  assign bus_writedata  = (state_r == DATA_WR) ? wdata_r : 32'h0;
  assign bus_byteenable = active_s ? be_r : 4'h0;
  assign bus_error      = bus_error_r;

  // A reset in the completing cycle suppresses the ready pulse.
  assign finish_s       = (done_s || abort_s) && !reset;
  assign rdata_s        = abort_s ? ERR_READDATA : bus_readdata;
  assign instr_ready    = finish_s && (state_r == INSTR);
  assign data_ready     = finish_s && ((state_r == DATA_RD) || (state_r == DATA_WR));
  assign instr_readdata = instr_ready ? rdata_s : 32'h0;
  assign data_readdata  = (finish_s && (state_r == DATA_RD)) ? rdata_s : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut 0 has fixed data priority and a 4-cycle
// watchdog, dut 1 is round-robin with no watchdog.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        instr_req[2];
  logic [31:0] instr_address[2];
  logic [31:0] instr_readdata[2];
  logic        instr_ready[2];
  logic        data_read[2];
  logic        data_write[2];
  logic [31:0] data_address[2];
  logic [31:0] data_writedata[2];
  logic [3:0]  data_byteenable[2];
  logic [31:0] data_readdata[2];
  logic        data_ready[2];
  logic [31:0] bus_address[2];
  logic        bus_read[2];
  logic        bus_write[2];
  logic [31:0] bus_writedata[2];
  logic [3:0]  bus_byteenable[2];
  logic        bus_waitrequest[2];
  logic [31:0] bus_readdata[2];
  logic        busy[2];
  logic        bus_error[2];

  int n_checks = 0;
  int n_fails  = 0;

  // Transaction-level reference model, one per DUT.
  bit          m_busy[2];
  int          m_kind[2];   // 0 fetch, 1 load, 2 store
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_be[2];
  int          m_stall[2];
  bit          m_last_data[2];
  bit          m_err[2];

  mem_port_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset),
    .instr_req(instr_req[0]), .instr_address(instr_address[0]),
    .instr_readdata(instr_readdata[0]), .instr_ready(instr_ready[0]),
    .data_read(data_read[0]), .data_write(data_write[0]),
    .data_address(data_address[0]), .data_writedata(data_writedata[0]),
    .data_byteenable(data_byteenable[0]), .data_readdata(data_readdata[0]),
    .data_ready(data_ready[0]), .bus_address(bus_address[0]),
    .bus_read(bus_read[0]), .bus_write(bus_write[0]),
    .bus_writedata(bus_writedata[0]), .bus_byteenable(bus_byteenable[0]),
    .bus_waitrequest(bus_waitrequest[0]), .bus_readdata(bus_readdata[0]),
    .busy(busy[0]), .bus_error(bus_error[0])
  );

  mem_port_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .instr_req(instr_req[1]), .instr_address(instr_address[1]),
    .instr_readdata(instr_readdata[1]), .instr_ready(instr_ready[1]),
    .data_read(data_read[1]), .data_write(data_write[1]),
    .data_address(data_address[1]), .data_writedata(data_writedata[1]),
    .data_byteenable(data_byteenable[1]), .data_readdata(data_readdata[1]),
    .data_ready(data_ready[1]), .bus_address(bus_address[1]),
    .bus_read(bus_read[1]), .bus_write(bus_write[1]),
    .bus_writedata(bus_writedata[1]), .bus_byteenable(bus_byteenable[1]),
    .bus_waitrequest(bus_waitrequest[1]), .bus_readdata(bus_readdata[1]),
    .busy(busy[1]), .bus_error(bus_error[1])
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    for (int k = 0; k < 2; k++) begin
      instr_req[k] = 1'b0; instr_address[k] = 32'h0;
      data_read[k] = 1'b0; data_write[k] = 1'b0;
      data_address[k] = 32'h0; data_writedata[k] = 32'h0; data_byteenable[k] = 4'h0;
      bus_waitrequest[k] = 1'b0; bus_readdata[k] = 32'h0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_kind[k] = 0; m_addr[k] = 32'h0; m_wdata[k] = 32'h0;
      m_be[k] = 4'h0; m_stall[k] = 0; m_last_data[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      instr_req[k] = 1'b1; data_write[k] = 1'b1; data_address[k] = 32'h44;
      data_byteenable[k] = 4'hF; bus_readdata[k] = 32'h55AA55AA;
    end
    tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (busy[k] !== 1'b0) begin n_fails++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
      n_checks++; if ({bus_read[k], bus_write[k]} !== 2'b00) begin n_fails++; $display("FAIL reset_strobes[%0d]: got %b expected 00", k, {bus_read[k], bus_write[k]}); end
      n_checks++; if ({bus_address[k], bus_writedata[k], bus_byteenable[k]} !== 68'h0) begin n_fails++; $display("FAIL reset_bus[%0d]: got %h/%h/%h expected zeros", k, bus_address[k], bus_writedata[k], bus_byteenable[k]); end
      n_checks++; if ({instr_ready[k], data_ready[k], bus_error[k]} !== 3'b000) begin n_fails++; $display("FAIL reset_flags[%0d]: got %b expected 000", k, {instr_ready[k], data_ready[k], bus_error[k]}); end
    end
    do_reset();
  endtask

  task automatic test_instr_fetch;
    do_reset();
    instr_req[0] = 1'b1; instr_address[0] = 32'hBFC00000;
    bus_waitrequest[0] = 1'b0; bus_readdata[0] = 32'h24020005;
    #1;
    n_checks++; if (bus_read[0] !== 1'b0) begin n_fails++; $display("FAIL fetch_idle_read: got %b expected 0", bus_read[0]); end
    tick(); #1;
    n_checks++; if (bus_read[0] !== 1'b1 || bus_byteenable[0] !== 4'hF) begin n_fails++; $display("FAIL fetch_strobe: got rd=%b be=%h expected rd=1 be=f", bus_read[0], bus_byteenable[0]); end
    n_checks++; if (bus_address[0] !== 32'hBFC00000) begin n_fails++; $display("FAIL fetch_addr: got %h expected bfc00000", bus_address[0]); end
    n_checks++; if (instr_ready[0] !== 1'b1 || instr_readdata[0] !== 32'h24020005) begin n_fails++; $display("FAIL fetch_data: got rdy=%b data=%h expected rdy=1 data=24020005", instr_ready[0], instr_readdata[0]); end
    instr_req[0] = 1'b0;
    tick(); #1;
    n_checks++; if (busy[0] !== 1'b0 || instr_ready[0] !== 1'b0 || instr_readdata[0] !== 32'h0) begin n_fails++; $display("FAIL fetch_after: got busy=%b rdy=%b data=%h expected 0/0/0", busy[0], instr_ready[0], instr_readdata[0]); end
  endtask

  task automatic test_priority;
    do_reset();
    instr_req[0] = 1'b1; instr_address[0] = 32'h00000400;
    data_write[0] = 1'b1; data_address[0] = 32'h00001000;
    data_writedata[0] = 32'hDEADBEEF; data_byteenable[0] = 4'b0011;
    bus_readdata[0] = 32'h11112222;
    tick(); #1;
    n_checks++; if (bus_write[0] !== 1'b1 || bus_read[0] !== 1'b0) begin n_fails++; $display("FAIL prio_write_first: got wr=%b rd=%b expected wr=1 rd=0", bus_write[0], bus_read[0]); end
    n_checks++; if (bus_byteenable[0] !== 4'b0011 || bus_writedata[0] !== 32'hDEADBEEF || bus_address[0] !== 32'h1000) begin n_fails++; $display("FAIL prio_write_bus: got be=%h wd=%h a=%h expected 3/deadbeef/1000", bus_byteenable[0], bus_writedata[0], bus_address[0]); end
    n_checks++; if (data_ready[0] !== 1'b1 || instr_ready[0] !== 1'b0 || data_readdata[0] !== 32'h0) begin n_fails++; $display("FAIL prio_write_ready: got d=%b i=%b rdata=%h expected 1/0/0", data_ready[0], instr_ready[0], data_readdata[0]); end
    data_write[0] = 1'b0;
    tick(); #1;
    n_checks++; if (busy[0] !== 1'b0 || bus_write[0] !== 1'b0) begin n_fails++; $display("FAIL prio_gap_idle: got busy=%b wr=%b expected 0/0", busy[0], bus_write[0]); end
    tick(); #1;
    n_checks++; if (bus_read[0] !== 1'b1 || bus_address[0] !== 32'h400 || bus_byteenable[0] !== 4'hF) begin n_fails++; $display("FAIL prio_fetch_bus: got rd=%b a=%h be=%h expected 1/400/f", bus_read[0], bus_address[0], bus_byteenable[0]); end
    n_checks++; if (instr_ready[0] !== 1'b1 || instr_readdata[0] !== 32'h11112222) begin n_fails++; $display("FAIL prio_fetch_data: got rdy=%b data=%h expected 1/11112222", instr_ready[0], instr_readdata[0]); end
    instr_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int order[4];
    int n;
    int exp_order[4] = '{1, 0, 1, 0};
    do_reset();
    n = 0;
    instr_req[1] = 1'b1; instr_address[1] = 32'h100;
    data_read[1] = 1'b1; data_address[1] = 32'h200; data_byteenable[1] = 4'hF;
    bus_readdata[1] = 32'hCAFE0001;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (instr_ready[1]) begin order[n] = 0; n++; end
      else if (data_ready[1]) begin order[n] = 1; n++; end
      tick();
    end
    n_checks++; if (n !== 4) begin n_fails++; $display("FAIL rr_count: got %0d grants expected 4 within budget", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++; if (order[i] !== exp_order[i]) begin n_fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d (1=data 0=instr)", i, order[i], exp_order[i]); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wait_states;
    do_reset();
    data_read[0] = 1'b1; data_address[0] = 32'h2000; data_byteenable[0] = 4'b1100;
    bus_waitrequest[0] = 1'b1; bus_readdata[0] = 32'hDEAD0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus_read[0] !== 1'b1 || bus_address[0] !== 32'h2000 || bus_byteenable[0] !== 4'b1100 || data_ready[0] !== 1'b0) begin n_fails++; $display("FAIL wait_stable[%0d]: got rd=%b a=%h be=%h rdy=%b expected 1/2000/c/0", i, bus_read[0], bus_address[0], bus_byteenable[0], data_ready[0]); end
      tick();
    end
    bus_waitrequest[0] = 1'b0; bus_readdata[0] = 32'h12345678;
    #1;
    n_checks++; if (data_ready[0] !== 1'b1 || data_readdata[0] !== 32'h12345678 || bus_read[0] !== 1'b1) begin n_fails++; $display("FAIL wait_done: got rdy=%b data=%h rd=%b expected 1/12345678/1", data_ready[0], data_readdata[0], bus_read[0]); end
    data_read[0] = 1'b0;
    tick(); #1;
    n_checks++; if (busy[0] !== 1'b0 || data_ready[0] !== 1'b0) begin n_fails++; $display("FAIL wait_after: got busy=%b rdy=%b expected 0/0", busy[0], data_ready[0]); end
  endtask

  task automatic test_timeout;
    do_reset();
    instr_req[0] = 1'b1; instr_address[0] = 32'h80;
    bus_waitrequest[0] = 1'b1; bus_readdata[0] = 32'hAAAA5555;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (instr_ready[0] !== 1'b0 || bus_read[0] !== 1'b1) begin n_fails++; $display("FAIL to_stall[%0d]: got rdy=%b rd=%b expected 0/1", i, instr_ready[0], bus_read[0]); end
      tick();
    end
    #1;
    n_checks++; if (instr_ready[0] !== 1'b1 || instr_readdata[0] !== 32'hFFFFFFFF) begin n_fails++; $display("FAIL to_abort: got rdy=%b data=%h expected 1/ffffffff", instr_ready[0], instr_readdata[0]); end
    n_checks++; if (bus_error[0] !== 1'b0) begin n_fails++; $display("FAIL to_err_early: got %b expected 0", bus_error[0]); end
    instr_req[0] = 1'b0;
    tick(); #1;
    n_checks++; if (bus_error[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fails++; $display("FAIL to_err_set: got err=%b busy=%b expected 1/0", bus_error[0], busy[0]); end
    bus_waitrequest[0] = 1'b0; data_write[0] = 1'b1; data_address[0] = 32'h10;
    tick(); #1;
    n_checks++; if (data_ready[0] !== 1'b1) begin n_fails++; $display("FAIL to_next_txn: got rdy=%b expected 1", data_ready[0]); end
    data_write[0] = 1'b0;
    tick(); #1;
    n_checks++; if (bus_error[0] !== 1'b1) begin n_fails++; $display("FAIL to_err_sticky: got %b expected 1", bus_error[0]); end
    do_reset(); #1;
    n_checks++; if (bus_error[0] !== 1'b0) begin n_fails++; $display("FAIL to_err_reset: got %b expected 0", bus_error[0]); end
  endtask

  task automatic test_reset_mid;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      data_write[0] = 1'b1; data_address[0] = 32'h3000;
      data_writedata[0] = 32'h0BADF00D; data_byteenable[0] = 4'hF;
      bus_waitrequest[0] = 1'b1;
      tick(); #1;
      n_checks++; if (bus_write[0] !== 1'b1) begin n_fails++; $display("FAIL rmid_write[%0d]: got %b expected 1", v, bus_write[0]); end
      reset = 1'b1;
      bus_waitrequest[0] = (v == 0) ? 1'b1 : 1'b0;
      #1;
      n_checks++; if (data_ready[0] !== 1'b0) begin n_fails++; $display("FAIL rmid_no_ready[%0d]: got %b expected 0", v, data_ready[0]); end
      tick(); #1;
      n_checks++; if (bus_write[0] !== 1'b0 || busy[0] !== 1'b0 || data_ready[0] !== 1'b0 || bus_error[0] !== 1'b0) begin n_fails++; $display("FAIL rmid_after[%0d]: got wr=%b busy=%b rdy=%b err=%b expected 0/0/0/0", v, bus_write[0], busy[0], data_ready[0], bus_error[0]); end
      reset = 1'b0;
      clear_inputs();
    end
  endtask

  task automatic test_random;
    bit ip[2], dp[2], fin[2], ab[2];
    do_reset();
    ip = '{1'b0, 1'b0}; dp = '{1'b0, 1'b0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!ip[k] && ($urandom_range(0, 2) == 0)) begin
          ip[k] = 1'b1; instr_address[k] = $urandom;
        end
        instr_req[k] = ip[k];
        if (!dp[k] && ($urandom_range(0, 2) == 0)) begin
          int op;
          op = $urandom_range(0, 2);
          dp[k] = 1'b1;
          data_read[k] = (op != 1); data_write[k] = (op != 0);
          data_address[k] = $urandom; data_writedata[k] = $urandom;
          data_byteenable[k] = 4'($urandom);
        end
        if (!dp[k]) begin data_read[k] = 1'b0; data_write[k] = 1'b0; end
        bus_waitrequest[k] = ($urandom_range(0, 9) < 4);
        bus_readdata[k] = $urandom;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        int to;
        logic [31:0] e_rd;
        logic e_ir, e_dr;
        to = (k == 0) ? 4 : 0;
        ab[k]  = m_busy[k] && bus_waitrequest[k] && (to > 0) && (m_stall[k] == to);
        fin[k] = m_busy[k] && (!bus_waitrequest[k] || ab[k]);
        e_rd   = ab[k] ? 32'hFFFFFFFF : bus_readdata[k];
        e_ir   = fin[k] && (m_kind[k] == 0);
        e_dr   = fin[k] && (m_kind[k] != 0);
        n_checks++; if (busy[k] !== m_busy[k] || bus_read[k] !== (m_busy[k] && m_kind[k] != 2) || bus_write[k] !== (m_busy[k] && m_kind[k] == 2)) begin n_fails++; $display("FAIL rnd_strobes[%0d] cyc %0d: got busy=%b rd=%b wr=%b model busy=%b kind=%0d", k, cyc, busy[k], bus_read[k], bus_write[k], m_busy[k], m_kind[k]); end
        n_checks++; if (bus_address[k] !== (m_busy[k] ? m_addr[k] : 32'h0) || bus_byteenable[k] !== (m_busy[k] ? m_be[k] : 4'h0)) begin n_fails++; $display("FAIL rnd_addr_be[%0d] cyc %0d: got %h/%h expected %h/%h", k, cyc, bus_address[k], bus_byteenable[k], m_busy[k] ? m_addr[k] : 32'h0, m_busy[k] ? m_be[k] : 4'h0); end
        n_checks++; if (bus_writedata[k] !== ((m_busy[k] && m_kind[k] == 2) ? m_wdata[k] : 32'h0)) begin n_fails++; $display("FAIL rnd_wdata[%0d] cyc %0d: got %h expected %h", k, cyc, bus_writedata[k], (m_busy[k] && m_kind[k] == 2) ? m_wdata[k] : 32'h0); end
        n_checks++; if (instr_ready[k] !== e_ir || instr_readdata[k] !== (e_ir ? e_rd : 32'h0)) begin n_fails++; $display("FAIL rnd_instr[%0d] cyc %0d: got %b/%h expected %b/%h", k, cyc, instr_ready[k], instr_readdata[k], e_ir, e_ir ? e_rd : 32'h0); end
        n_checks++; if (data_ready[k] !== e_dr || data_readdata[k] !== ((fin[k] && m_kind[k] == 1) ? e_rd : 32'h0)) begin n_fails++; $display("FAIL rnd_data[%0d] cyc %0d: got %b/%h expected %b/%h", k, cyc, data_ready[k], data_readdata[k], e_dr, (fin[k] && m_kind[k] == 1) ? e_rd : 32'h0); end
        n_checks++; if (bus_error[k] !== m_err[k]) begin n_fails++; $display("FAIL rnd_err[%0d] cyc %0d: got %b expected %b", k, cyc, bus_error[k], m_err[k]); end
        if (e_ir) ip[k] = 1'b0;
        if (e_dr) dp[k] = 1'b0;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k]) begin
          if (fin[k]) begin
            m_busy[k] = 1'b0; m_stall[k] = 0;
            if (ab[k]) m_err[k] = 1'b1;
          end else begin
            m_stall[k]++;
          end
        end else if ((data_read[k] || data_write[k]) &&
                     (k == 0 || !instr_req[k] || !m_last_data[k])) begin
          m_busy[k] = 1'b1; m_kind[k] = data_write[k] ? 2 : 1;
          m_addr[k] = data_address[k]; m_wdata[k] = data_writedata[k];
          m_be[k] = data_byteenable[k]; m_last_data[k] = 1'b1;
        end else if (instr_req[k]) begin
          m_busy[k] = 1'b1; m_kind[k] = 0; m_addr[k] = instr_address[k];
          m_wdata[k] = 32'h0; m_be[k] = 4'hF; m_last_data[k] = 1'b0;
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_instr_fetch();
    test_priority();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
